reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of in-flight instruction entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 6, physical register tag width.
REQ-003 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dispatch_valid  input  1  renamed instruction presented this cycle.
REQ-006 SHALL have port dispatch_has_rd  input  1  instruction writes a non-x0 destination.
REQ-007 SHALL have port dispatch_old_tag  input  TAG_W  previous physical mapping of rd, freed at retire.
REQ-008 SHALL have port dispatch_ready  output  1  entry available; dispatch accepted when valid&&ready.
REQ-009 SHALL have port dispatch_rob_index  output  log2(DEPTH)  index assigned to the accepted instruction (current tail).
REQ-010 SHALL have ports wakeup_{0..3}_active  input  1  completion broadcast k valid.
REQ-011 SHALL have ports wakeup_{0..3}_rob_index  input  log2(DEPTH)  entry completed by broadcast k.
REQ-012 SHALL have ports freed_tag_1, freed_tag_2  output  TAG_W  tags returned to rename; 0 means none.
REQ-013 SHALL have port rob_count  output  log2(DEPTH)+1  occupied entries.
REQ-014 SHALL have port rob_empty  output  1  rob_count==0.

Function
REQ-015 Entry fields: valid, complete, has_rd, old_tag; circular buffer with head, tail pointers and count.
REQ-016 Accepted dispatch SHALL write tail entry (valid=1, complete=0) and advance tail, wrapping DEPTH-1 -> 0.
REQ-017 dispatch_ready SHALL be count<DEPTH from registered count; no same-cycle credit from retirement when full.
REQ-018 Active wakeup targeting a valid entry SHALL set its complete bit; wakeups to invalid entries ignored; duplicate/simultaneous wakeups to same index harmless.
REQ-019 Retire in order, up to 2 per cycle: head retires if complete; head+1 retires only if head retires and head+1 valid and complete.
REQ-020 Retired entries SHALL be invalidated; head advances by retire count with wrap-around.
REQ-021 freed_tag_1/2 SHALL be registered: cycle after retirement, old_tag of 1st/2nd retired entry if has_rd and old_tag!=0, else 0.
REQ-022 freed_tag outputs SHALL be 0 in any cycle following no retirement (single-cycle pulse per tag).
REQ-023 count next = count + accepted dispatch - retire count; simultaneous dispatch and retire SHALL both take effect.
REQ-024 Dispatch into an entry freed in the same cycle SHALL not occur (guaranteed by REQ-017).

Reset
REQ-025 Reset low SHALL immediately clear head, tail, count, all valid/complete bits, freed_tag_1/2 to 0; dispatch_ready=1, rob_empty=1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight entries without emitting freed tags.

Configuration
REQ-027 Macro ROB_WAKEUP_BYPASS_EN defined: a wakeup arriving this cycle for head/head+1 SHALL count as complete for this cycle's retire decision.
REQ-028 Macro undefined: retire decision SHALL use registered complete bits only, adding one cycle of completion-to-retire latency.

Structure
REQ-029 Package rob_pkg SHALL hold TAG_W, ROB_DEPTH, ROB_IDX_W, NULL_TAG=0 and the rob_entry_t struct.
REQ-030 Sub-module rob_retire_select SHALL compute retire count and freed-tag candidates from head entries.

Verification
REQ-031 Reset, dispatch 3 (old tags 5,6,7), wake index 0 -> freed_tag_1=5 one cycle after retire, freed_tag_2=0.
REQ-032 Wake indices 2 then 1 on later cycles -> nothing retires until 1 completes; then freed_tag_1=6, freed_tag_2=7 together.
REQ-033 Dispatch 16 without wakeups -> dispatch_ready=0, rob_count=16; extra dispatch_valid ignored; wake head -> ready next cycle.
REQ-034 Fill/retire 40 entries cycling -> indices wrap 15->0, freed tags match dispatch order, rob_count returns to 0.
REQ-035 Dispatch has_rd=0 and old_tag=0 entries, wake -> retire with freed tags 0; with bypass macro, same-cycle wake of head retires that cycle, without it one cycle later.
REQ-036 Reset low with 4 entries in flight -> rob_empty=1 immediately, no nonzero freed tag afterwards.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared constants and types for the reorder buffer slice.
//   TAG_W      : physical register tag width
//   ROB_DEPTH  : default number of in-flight entries (power of two)
//   ROB_IDX_W  : index width for ROB_DEPTH entries
//   NULL_TAG   : tag value meaning "nothing to free"
//   rob_entry_t: layout of one entry at the package default widths
// -----------------------------------------------------------------------------
package rob_pkg;

  localparam int TAG_W     = 6;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef struct packed {
    logic             valid;
    logic             complete;
    logic             has_rd;
    logic [TAG_W-1:0] old_tag;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles the dispatch handshake, the four completion broadcasts and the
// retirement / occupancy outputs of the reorder buffer.
//   master : the pipeline side (drives dispatch and wakeups)
//   slave  : the reorder buffer side
// Parameters DEPTH and TAG_W must match the reorder_buffer instance.
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int DEPTH = rob_pkg::ROB_DEPTH,
  parameter int TAG_W = rob_pkg::TAG_W
) ();

  localparam int IDX_W = $clog2(DEPTH);

  logic             dispatch_valid;
  logic             dispatch_has_rd;
  logic [TAG_W-1:0] dispatch_old_tag;
  logic             dispatch_ready;
  logic [IDX_W-1:0] dispatch_rob_index;

  logic             wakeup_0_active;
  logic [IDX_W-1:0] wakeup_0_rob_index;
  logic             wakeup_1_active;
  logic [IDX_W-1:0] wakeup_1_rob_index;
  logic             wakeup_2_active;
  logic [IDX_W-1:0] wakeup_2_rob_index;
  logic             wakeup_3_active;
  logic [IDX_W-1:0] wakeup_3_rob_index;

  logic [TAG_W-1:0] freed_tag_1;
  logic [TAG_W-1:0] freed_tag_2;
  logic [IDX_W:0]   rob_count;
  logic             rob_empty;

  modport master (
    output dispatch_valid, dispatch_has_rd, dispatch_old_tag,
    output wakeup_0_active, wakeup_0_rob_index, wakeup_1_active, wakeup_1_rob_index,
    output wakeup_2_active, wakeup_2_rob_index, wakeup_3_active, wakeup_3_rob_index,
    input  dispatch_ready, dispatch_rob_index,
    input  freed_tag_1, freed_tag_2, rob_count, rob_empty
  );

  modport slave (
    input  dispatch_valid, dispatch_has_rd, dispatch_old_tag,
    input  wakeup_0_active, wakeup_0_rob_index, wakeup_1_active, wakeup_1_rob_index,
    input  wakeup_2_active, wakeup_2_rob_index, wakeup_3_active, wakeup_3_rob_index,
    output dispatch_ready, dispatch_rob_index,
    output freed_tag_1, freed_tag_2, rob_count, rob_empty
  );

endinterface

// File: rtl/reorder_buffer_retire_select.sv
// -----------------------------------------------------------------------------
// rob_retire_select
// Decides how many of the two oldest entries retire this cycle and which
// physical tags they hand back to rename.
//   i_valid0/1, i_complete0/1 : state of head and head+1 (complete may already
//                               include a same-cycle wakeup)
//   i_has_rd0/1, i_old_tag0/1 : destination info of head and head+1
//   o_retire_cnt              : 0, 1 or 2 entries retiring
//   o_tag1, o_tag2            : tag to free for 1st/2nd retiree, 0 if none
// -----------------------------------------------------------------------------
module rob_retire_select #(
  parameter int TAG_W = rob_pkg::TAG_W
) (
  input  logic             i_valid0,
  input  logic             i_complete0,
  input  logic             i_has_rd0,
  input  logic [TAG_W-1:0] i_old_tag0,
  input  logic             i_valid1,
  input  logic             i_complete1,
  input  logic             i_has_rd1,
  input  logic [TAG_W-1:0] i_old_tag1,
  output logic [1:0]       o_retire_cnt,
  output logic [TAG_W-1:0] o_tag1,
  output logic [TAG_W-1:0] o_tag2
);
  import rob_pkg::*;

  localparam logic [TAG_W-1:0] L_NULL = TAG_W'(NULL_TAG);

  logic w_ret0;
  logic w_ret1;

  // In-order: the second entry may only go when the head goes with it.
  assign w_ret0 = i_valid0 & i_complete0;
  assign w_ret1 = w_ret0 & i_valid1 & i_complete1;

  assign o_retire_cnt = {w_ret1, w_ret0 & ~w_ret1};

  // A tag of 0 is the architectural x0 mapping and is never returned.
  assign o_tag1 = (w_ret0 && i_has_rd0 && (i_old_tag0 != L_NULL)) ? i_old_tag0 : L_NULL;
  assign o_tag2 = (w_ret1 && i_has_rd1 && (i_old_tag1 != L_NULL)) ? i_old_tag1 : L_NULL;

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order retirement buffer for renamed instructions. Entries are
// allocated at the tail on dispatch, marked complete by up to four wakeup
// broadcasts per cycle, and retired from the head up to two per cycle. The
// previous physical mapping of each retired destination is returned to
// rename one cycle after retirement as a single-cycle pulse.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-low; discards every in-flight entry
//   bus    : reorder_buffer_if.slave (dispatch handshake, wakeups,
//            freed tags, occupancy)
//
// Configuration
//   ROB_WAKEUP_BYPASS_EN : when defined, a wakeup arriving this cycle for
//   head or head+1 counts as complete for this cycle's retire decision.
//   When undefined, only registered complete bits are used, which adds one
//   cycle from completion to retirement.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int DEPTH = rob_pkg::ROB_DEPTH,
  parameter int TAG_W = rob_pkg::TAG_W
) (
  input  logic           clk,
  input  logic           reset,
  reorder_buffer_if.slave bus
);
  import rob_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] L_FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_complete;
  logic [DEPTH-1:0] r_has_rd;
  logic [TAG_W-1:0] r_old_tag [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  logic [TAG_W-1:0] r_freed_1;
  logic [TAG_W-1:0] r_freed_2;

  logic             w_ready;
  logic             w_accept;
  logic [IDX_W-1:0] w_head1;
  logic [3:0]       w_wk_act;
  logic [IDX_W-1:0] w_wk_idx [4];
  logic             w_cmp0;
  logic             w_cmp1;
  logic [1:0]       w_retire_cnt;
  logic [TAG_W-1:0] w_tag1;
  logic [TAG_W-1:0] w_tag2;
  logic [IDX_W:0]   w_count_next;

  assign w_wk_act    = {bus.wakeup_3_active, bus.wakeup_2_active,
                        bus.wakeup_1_active, bus.wakeup_0_active};
  assign w_wk_idx[0] = bus.wakeup_0_rob_index;
  assign w_wk_idx[1] = bus.wakeup_1_rob_index;
  assign w_wk_idx[2] = bus.wakeup_2_rob_index;
  assign w_wk_idx[3] = bus.wakeup_3_rob_index;

  // Readiness comes from the registered count only, so a full buffer never
  // reuses the slot that is retiring in the same cycle.
  assign w_ready  = (r_count < L_FULL);
  assign w_accept = bus.dispatch_valid & w_ready;
  assign w_head1  = r_head + IDX_W'(1);

`ifdef ROB_WAKEUP_BYPASS_EN
  logic w_wake_head;
  logic w_wake_head1;

  always_comb begin
    w_wake_head  = 1'b0;
    w_wake_head1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_wk_act[k] && (w_wk_idx[k] == r_head))  w_wake_head  = 1'b1;
      if (w_wk_act[k] && (w_wk_idx[k] == w_head1)) w_wake_head1 = 1'b1;
    end
  end

  assign w_cmp0 = r_complete[r_head]  | w_wake_head;
  assign w_cmp1 = r_complete[w_head1] | w_wake_head1;
`else
  assign w_cmp0 = r_complete[r_head];
  assign w_cmp1 = r_complete[w_head1];
`endif

  rob_retire_select #(
    .TAG_W (TAG_W)
  ) u_retire_select (
    .i_valid0     (r_valid[r_head]),
    .i_complete0  (w_cmp0),
    .i_has_rd0    (r_has_rd[r_head]),
    .i_old_tag0   (r_old_tag[r_head]),
    .i_valid1     (r_valid[w_head1]),
    .i_complete1  (w_cmp1),
    .i_has_rd1    (r_has_rd[w_head1]),
    .i_old_tag1   (r_old_tag[w_head1]),
    .o_retire_cnt (w_retire_cnt),
    .o_tag1       (w_tag1),
    .o_tag2       (w_tag2)
  );

  assign w_count_next = r_count + (IDX_W+1)'(w_accept) - (IDX_W+1)'(w_retire_cnt);

  // Control state. Statement order matters: wakeups set complete, retirement
  // then clears its slots, and a dispatch finally claims the tail slot (which
  // is never a retiring slot, since dispatch is blocked while full).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_freed_1  <= '0;
      r_freed_2  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_wk_act[k] && r_valid[w_wk_idx[k]]) r_complete[w_wk_idx[k]] <= 1'b1;
      end
      if (w_retire_cnt != 2'd0) begin
        r_valid[r_head]    <= 1'b0;
        r_complete[r_head] <= 1'b0;
      end
      if (w_retire_cnt == 2'd2) begin
        r_valid[w_head1]    <= 1'b0;
        r_complete[w_head1] <= 1'b0;
      end
      if (w_accept) begin
        r_valid[r_tail]    <= 1'b1;
        r_complete[r_tail] <= 1'b0;
      end
      r_head    <= r_head + IDX_W'(w_retire_cnt);
      r_tail    <= r_tail + IDX_W'(w_accept);
      r_count   <= w_count_next;
      // Candidates are 0 whenever nothing retires, giving one-cycle pulses.
      r_freed_1 <= w_tag1;
      r_freed_2 <= w_tag2;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_has_rd[r_tail]  <= bus.dispatch_has_rd;
      r_old_tag[r_tail] <= bus.dispatch_old_tag;
    end
  end

  assign bus.dispatch_ready     = w_ready;
  assign bus.dispatch_rob_index = r_tail;
  assign bus.freed_tag_1        = r_freed_1;
  assign bus.freed_tag_2        = r_freed_2;
  assign bus.rob_count          = r_count;
  assign bus.rob_empty          = (r_count == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed scoreboard bench for reorder_buffer. Stimulus pushes the expected
// freed-tag pulse (cycle, tag1, tag2) whenever it causes a retirement that
// returns a tag; a negedge monitor pops and compares every nonzero pulse.
// Occupancy, readiness and index values are checked inline.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

`ifdef ROB_WAKEUP_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  reorder_buffer_if #(.DEPTH(16), .TAG_W(6)) bus ();

  reorder_buffer #(.DEPTH(16), .TAG_W(6)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int cyc;
    int t1;
    int t2;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   exp_tail = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: every nonzero freed-tag pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.freed_tag_1 != 6'd0 || bus.freed_tag_2 != 6'd0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_freed: got %0d/%0d want none",
                 int'(bus.freed_tag_1), int'(bus.freed_tag_2));
      end else begin
        e = sb.pop_front();
        chk("freed_cycle", cyc, e.cyc);
        chk("freed_tag_1", int'(bus.freed_tag_1), e.t1);
        chk("freed_tag_2", int'(bus.freed_tag_2), e.t2);
      end
    end
  end

  task automatic clear_inputs();
    bus.dispatch_valid     = 1'b0;
    bus.dispatch_has_rd    = 1'b0;
    bus.dispatch_old_tag   = 6'd0;
    bus.wakeup_0_active    = 1'b0;
    bus.wakeup_0_rob_index = 4'd0;
    bus.wakeup_1_active    = 1'b0;
    bus.wakeup_1_rob_index = 4'd0;
    bus.wakeup_2_active    = 1'b0;
    bus.wakeup_2_rob_index = 4'd0;
    bus.wakeup_3_active    = 1'b0;
    bus.wakeup_3_rob_index = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of optional dispatch plus optional wakeup on broadcast 0.
  // exp_t1 >= 0 means the wake retires the head alone and frees that tag.
  task automatic drive(input bit dv, input bit hrd, input int tag,
                       input bit wv, input int widx, input int exp_t1);
    exp_t e;
    if (dv) begin
      chk("dispatch_rob_index", int'(bus.dispatch_rob_index), exp_tail);
      bus.dispatch_valid   = 1'b1;
      bus.dispatch_has_rd  = hrd;
      bus.dispatch_old_tag = 6'(tag);
    end
    if (wv) begin
      bus.wakeup_0_active    = 1'b1;
      bus.wakeup_0_rob_index = 4'(widx);
      if (exp_t1 >= 0) begin
        e.cyc = cyc + 2 - BYP;
        e.t1  = exp_t1;
        e.t2  = 0;
        sb.push_back(e);
      end
    end
    tick();
    clear_inputs();
    if (dv) exp_tail = (exp_tail + 1) % 16;
  endtask

  initial begin
    exp_t e;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_ready", int'(bus.dispatch_ready), 1);
    chk("reset_empty", int'(bus.rob_empty), 1);
    chk("reset_count", int'(bus.rob_count), 0);
    chk("reset_freed_1", int'(bus.freed_tag_1), 0);
    chk("reset_freed_2", int'(bus.freed_tag_2), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three dispatches, head completes alone.
    drive(1, 1, 5, 0, 0, -1);
    drive(1, 1, 6, 0, 0, -1);
    drive(1, 1, 7, 0, 0, -1);
    chk("count_after_3", int'(bus.rob_count), 3);
    drive(0, 0, 0, 1, 0, 5);
    repeat (3) tick();
    chk("count_after_first_retire", int'(bus.rob_count), 2);

    // Younger entry completes first: nothing may retire until index 1 does.
    drive(0, 0, 0, 1, 2, -1);
    repeat (3) tick();
    chk("count_blocked_head", int'(bus.rob_count), 2);
    e.cyc = cyc + 2 - BYP;
    e.t1  = 6;
    e.t2  = 7;
    sb.push_back(e);
    bus.wakeup_1_active    = 1'b1;
    bus.wakeup_1_rob_index = 4'd1;
    bus.wakeup_3_active    = 1'b1;
    bus.wakeup_3_rob_index = 4'd1;
    tick();
    clear_inputs();
    repeat (3) tick();
    chk("count_after_pair", int'(bus.rob_count), 0);
    chk("empty_after_pair", int'(bus.rob_empty), 1);

    // Fill to capacity; further dispatch must be ignored.
    for (int i = 0; i < 16; i++) drive(1, 1, 10 + i, 0, 0, -1);
    chk("full_ready", int'(bus.dispatch_ready), 0);
    chk("full_count", int'(bus.rob_count), 16);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_has_rd  = 1'b1;
    bus.dispatch_old_tag = 6'd63;
    tick();
    tick();
    clear_inputs();
    chk("full_count_hold", int'(bus.rob_count), 16);
    chk("full_index_hold", int'(bus.dispatch_rob_index), exp_tail);
    drive(0, 0, 0, 1, 3, 10);
    tick();
    chk("ready_after_head_retire", int'(bus.dispatch_ready), 1);
    chk("count_after_head_retire", int'(bus.rob_count), 15);
    for (int i = 1; i < 16; i++) drive(0, 0, 0, 1, (3 + i) % 16, 10 + i);
    repeat (3) tick();
    chk("count_drained", int'(bus.rob_count), 0);
    chk("empty_drained", int'(bus.rob_empty), 1);

    // Streaming: dispatch one while waking the previous one, 40 entries.
    for (int i = 0; i < 40; i++)
      drive(1, 1, 20 + i, i > 0, (3 + i - 1) % 16, 20 + i - 1);
    drive(0, 0, 0, 1, (3 + 39) % 16, 59);
    repeat (3) tick();
    chk("count_after_stream", int'(bus.rob_count), 0);

    // Entries that free nothing, and completion-to-retire latency.
    drive(1, 0, 9, 0, 0, -1);
    drive(1, 1, 0, 0, 0, -1);
    chk("count_null_tags", int'(bus.rob_count), 2);
    drive(0, 0, 0, 1, 11, -1);
    chk("retire_latency", int'(bus.rob_count), 2 - BYP);
    tick();
    chk("count_after_null_1", int'(bus.rob_count), 1);
    drive(0, 0, 0, 1, 12, -1);
    tick();
    chk("count_after_null_2", int'(bus.rob_count), 0);

    // Reset with four entries in flight, two of them already complete.
    for (int i = 0; i < 4; i++) drive(1, 1, 40 + i, 0, 0, -1);
    bus.wakeup_1_active    = 1'b1;
    bus.wakeup_1_rob_index = 4'd14;
    bus.wakeup_2_active    = 1'b1;
    bus.wakeup_2_rob_index = 4'd15;
    tick();
    clear_inputs();
    chk("count_before_reset", int'(bus.rob_count), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", int'(bus.rob_empty), 1);
    chk("midrst_count", int'(bus.rob_count), 0);
    chk("midrst_ready", int'(bus.dispatch_ready), 1);
    chk("midrst_freed_1", int'(bus.freed_tag_1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_tail = 0;
    repeat (3) tick();
    drive(1, 1, 44, 0, 0, -1);
    chk("count_after_reset_dispatch", int'(bus.rob_count), 1);
    drive(0, 0, 0, 1, 0, 44);
    repeat (3) tick();
    chk("count_final", int'(bus.rob_count), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
